game_fsm_multilevel: RTL and testbench
======================================

Name: game_fsm_multilevel

Overview:
- Parametrised successor of the single-round game controller: Moore FSM driving screen/layer enables and jump/timer strobes.
- Adds a life budget, a multi-level progression, a pre-round countdown and edge-detected keys.
- Sits between keyboard decoder, map generator, physics/timer blocks and the render layers.

Parameters:
- LIVES, 3, lives granted at game start (>=1)
- LEVELS, 4, number of levels; clearing the last one wins (>=1)
- JUMPS_PER_LEVEL, 8, successful landings needed to clear a level (>=1)
- READY_TICKS, 3, countdown length in tick pulses before each round (0 = no countdown)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key  in  2  key code: 00 none, 01 left, 10 right, 11 space
- tick  in  1  one-cycle frame/second strobe for the countdown
- map_ready  in  1  map generator finished
- jump_fail  in  1  character has no block below
- time_elapsed  in  1  round timer expired
- character_landed  in  1  flight/fall animation finished
- start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en  out  1 each  layer enables
- bg_color_select  out  1  game background selected
- jump_left, jump_right  out  1  one-cycle jump strobes
- timer_start  out  1  round timer run/hold
- layer_generate  out  1  request a map layer
- countdown_en  out  1  countdown overlay on
- paused  out  1  pause overlay on / timer freeze
- end_text_select  out  2  00 time-out, 01 fell, 10 won
- lives_left  out  clog2(LIVES+1)  remaining lives
- level  out  clog2(LEVELS), min 1  current level, 0-based

Behaviour:
- Key events: key_q registered each cycle (reset 00). key_evt = (key != key_q) && (key != 00). A held key acts once; every key action below means key_evt with that code.
- Reset (wins over every input): state START, lives_left = LIVES, level = 0, jump count = 0, countdown = 0, all outputs low except start_screen_en = 1.
- All outputs are decoded from registered state and counters only. Input changes take effect on outputs one cycle later.
- START: start_screen_en. On space: lives = LIVES, level = 0, jumps = 0, go to PREPARE_MAP.
- PREPARE_MAP: start_screen_en, layer_generate.
  - On map_ready: countdown = READY_TICKS.
  - Go to COUNTDOWN, or to GAME_IDLE directly if READY_TICKS == 0.
- COUNTDOWN: game layers (blocks, time_bar, character, points, bg_color_select) plus countdown_en.
  - tick decrements the counter.
  - tick while counter == 1: go to GAME_IDLE.
  - Keys are ignored.
- GAME_IDLE: game layers on. Priority, highest first:
  - jump_fail: go to CHAR_FALL
  - time_elapsed: go to END_T
  - left: go to JUMP_L
  - right: go to JUMP_R
  - space: go to PAUSED (PAUSE_EN only)
- JUMP_L / JUMP_R: one cycle only. Pulses jump_left / jump_right and timer_start, then go to CHAR_FLY.
- CHAR_FLY: game layers on, timer_start = 1. On character_landed, with jumps+1 == JUMPS_PER_LEVEL:
  - if level == LEVELS-1: go to END_W
  - otherwise: level + 1, jumps = 0, go to PREPARE_MAP
- CHAR_FLY, character_landed with jumps+1 < JUMPS_PER_LEVEL: jumps + 1, go to GAME_IDLE.
- CHAR_FALL: game layers on, timer_start = 1. On character_landed:
  - if lives_left == 1: lives_left = 0, go to END_F
  - otherwise: lives_left - 1, jumps = 0, go to PREPARE_MAP (respawn with a new map, same level)
- END_T / END_F / END_W: end_screen_en, end_text_select = 00 / 01 / 10. On space: go to START.
- Inputs outside their consuming state are ignored. Examples: character_landed in JUMP_L, tick outside COUNTDOWN.
- Counters never wrap: lives stops at 0, level at LEVELS-1, jumps at JUMPS_PER_LEVEL.
- Any unused state encoding recovers to START next cycle, with START outputs.

Optional Feature:
- GAME_FSM_PAUSE_EN defined: PAUSED state is present.
  - Game layers on, paused = 1, timer_start = 0.
  - time_elapsed and jump_fail are ignored while paused.
  - space: back to GAME_IDLE.
- GAME_FSM_PAUSE_EN undefined: space in GAME_IDLE is ignored. The paused port remains and is tied 0.

Decomposition:
- Package game_fsm_pkg holds:
  - state encodings
  - key codes K_NONE / K_LEFT / K_RIGHT / K_SPACEBAR
  - end codes END_TIME / END_FALL / END_WIN
  - width helper functions for the counters
- Sub-module key_edge_detect (clk, rst, key -> key_evt, key_code) is natural and reusable by the menu logic.

Test Plan:
- rst mid-flight (CHAR_FLY, level 2) -> next cycle state START, lives_left = 3, level = 0, start_screen_en = 1, all others 0.
- Space held 10 cycles in START, then map_ready, then 3 ticks -> exactly one transition to PREPARE_MAP; countdown_en for 3 ticks; GAME_IDLE after the third tick.
- Left held 5 cycles in GAME_IDLE -> jump_left high exactly 1 cycle; timer_start high through CHAR_FLY; after landing, back in GAME_IDLE with jumps = 1.
- 8 landings at level 3 (LEVELS = 4) -> END_W, end_text_select = 10. 8 landings at level 0 -> level = 1, layer_generate asserted.
- jump_fail and time_elapsed in the same cycle -> CHAR_FALL. Three falls -> lives 3 → 2 → 1 → 0, END_F, end_text_select = 01.
- PAUSE_EN defined: space in GAME_IDLE -> paused = 1, time_elapsed ignored, second space -> GAME_IDLE. PAUSE_EN undefined -> state unchanged, paused = 0.

Source files
------------

// File: rtl/game_fsm_pkg.sv
// Shared types for the multi-level game controller: state encodings, key/end codes,
// counter width helpers and the state-to-layer decode. GAME_FSM_PAUSE_EN adds PAUSED.
package game_fsm_pkg;

    typedef enum logic [3:0] {
        S_START       = 4'd0,
        S_PREPARE_MAP = 4'd1,
        S_COUNTDOWN   = 4'd2,
        S_GAME_IDLE   = 4'd3,
        S_JUMP_L      = 4'd4,
        S_JUMP_R      = 4'd5,
        S_CHAR_FLY    = 4'd6,
        S_CHAR_FALL   = 4'd7,
        S_END_T       = 4'd8,
        S_END_F       = 4'd9,
        S_END_W       = 4'd10,
        S_PAUSED      = 4'd11
    } state_t;

    localparam logic [1:0] K_NONE     = 2'b00;
    localparam logic [1:0] K_LEFT     = 2'b01;
    localparam logic [1:0] K_RIGHT    = 2'b10;
    localparam logic [1:0] K_SPACEBAR = 2'b11;

    localparam logic [1:0] END_TIME = 2'b00;
    localparam logic [1:0] END_FALL = 2'b01;
    localparam logic [1:0] END_WIN  = 2'b10;

    typedef struct packed {
        logic       start_screen;
        logic       game;
        logic       end_screen;
        logic       jump_left;
        logic       jump_right;
        logic       timer_start;
        logic       layer_gen;
        logic       countdown;
        logic       paused;
        logic [1:0] end_text;
    } out_t;

    // Width of a counter holding 0..max_val.
    function automatic int cnt_w(int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of an index 0..n-1, never below one bit.
    function automatic int idx_w(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic out_t decode(state_t s);
        out_t o;
        o = '0;
        case (s)
            S_PREPARE_MAP: begin o.start_screen = 1'b1; o.layer_gen = 1'b1; end
            S_COUNTDOWN:   begin o.game = 1'b1; o.countdown = 1'b1; end
            S_GAME_IDLE:   o.game = 1'b1;
            S_JUMP_L:      begin o.game = 1'b1; o.jump_left = 1'b1; o.timer_start = 1'b1; end
            S_JUMP_R:      begin o.game = 1'b1; o.jump_right = 1'b1; o.timer_start = 1'b1; end
            S_CHAR_FLY,
            S_CHAR_FALL:   begin o.game = 1'b1; o.timer_start = 1'b1; end
            S_END_T:       begin o.end_screen = 1'b1; o.end_text = END_TIME; end
            S_END_F:       begin o.end_screen = 1'b1; o.end_text = END_FALL; end
            S_END_W:       begin o.end_screen = 1'b1; o.end_text = END_WIN; end
`ifdef GAME_FSM_PAUSE_EN
            S_PAUSED:      begin o.game = 1'b1; o.paused = 1'b1; end
`endif
            default:       o.start_screen = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns a level key code into a single-cycle event on each change to a non-idle code.
module key_edge_detect
    import game_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key,
    output logic       key_evt,
    output logic [1:0] key_code
);

    logic [1:0] key_q;

    always_ff @(posedge clk) begin
        if (rst) key_q <= K_NONE;
        else     key_q <= key;
    end

    assign key_evt  = (key != key_q) && (key != K_NONE);
    assign key_code = key;

endmodule

// File: rtl/game_fsm_multilevel.sv
// Multi-level game sequencer: lives, level progression, pre-round countdown, edge-detected keys.
// Define GAME_FSM_PAUSE_EN to add the PAUSED state toggled by space in GAME_IDLE.
//
// state       | meaning
// START       | title screen, wait for space
// PREPARE_MAP | request a new map layer, wait map_ready
// COUNTDOWN   | overlay counting tick pulses down to the round
// GAME_IDLE   | round running, waiting for a key or a fault
// JUMP_L/R    | one-cycle jump strobe
// CHAR_FLY    | jump animation, count landings
// CHAR_FALL   | fall animation, spend a life
// END_T/F/W   | end screen: time-out / fell / won
// PAUSED      | frozen round (pause build only)
module game_fsm_multilevel
    import game_fsm_pkg::*;
#(
    parameter int LIVES           = 3,
    parameter int LEVELS          = 4,
    parameter int JUMPS_PER_LEVEL = 8,
    parameter int READY_TICKS     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 key,
    input  logic                       tick,
    input  logic                       map_ready,
    input  logic                       jump_fail,
    input  logic                       time_elapsed,
    input  logic                       character_landed,
    output logic                       start_screen_en,
    output logic                       blocks_en,
    output logic                       time_bar_en,
    output logic                       character_en,
    output logic                       points_en,
    output logic                       end_screen_en,
    output logic                       bg_color_select,
    output logic                       jump_left,
    output logic                       jump_right,
    output logic                       timer_start,
    output logic                       layer_generate,
    output logic                       countdown_en,
    output logic                       paused,
    output logic [1:0]                 end_text_select,
    output logic [cnt_w(LIVES)-1:0]    lives_left,
    output logic [idx_w(LEVELS)-1:0]   level
);

    localparam int LW  = cnt_w(LIVES);
    localparam int LVW = idx_w(LEVELS);
    localparam int JW  = cnt_w(JUMPS_PER_LEVEL);
    localparam int CW  = cnt_w(READY_TICKS);

    logic          key_evt;
    logic [1:0]    key_code;
    state_t        state, state_nxt;
    logic [LW-1:0] lives_nxt;
    logic [LVW-1:0] level_nxt;
    logic [JW-1:0] jumps, jumps_nxt;
    logic [CW-1:0] cd, cd_nxt;
    out_t          outs;

    key_edge_detect u_key (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    wire space_evt = key_evt && (key_code == K_SPACEBAR);

    always_comb begin
        state_nxt = state;
        lives_nxt = lives_left;
        level_nxt = level;
        jumps_nxt = jumps;
        cd_nxt    = cd;
        case (state)
            S_START: if (space_evt) begin
                lives_nxt = LW'(LIVES);
                level_nxt = '0;
                jumps_nxt = '0;
                state_nxt = S_PREPARE_MAP;
            end
            S_PREPARE_MAP: if (map_ready) begin
                cd_nxt    = CW'(READY_TICKS);
                state_nxt = (READY_TICKS == 0) ? S_GAME_IDLE : S_COUNTDOWN;
            end
            // Terminal count at 1: the tick that empties the counter starts the round.
            S_COUNTDOWN: if (tick) begin
                if (cd <= CW'(1)) state_nxt = S_GAME_IDLE;
                if (cd != '0)     cd_nxt = cd - 1'b1;
            end
            S_GAME_IDLE: begin
                if (jump_fail)                              state_nxt = S_CHAR_FALL;
                else if (time_elapsed)                      state_nxt = S_END_T;
                else if (key_evt && key_code == K_LEFT)     state_nxt = S_JUMP_L;
                else if (key_evt && key_code == K_RIGHT)    state_nxt = S_JUMP_R;
`ifdef GAME_FSM_PAUSE_EN
                else if (space_evt)                         state_nxt = S_PAUSED;
`endif
            end
            S_JUMP_L, S_JUMP_R: state_nxt = S_CHAR_FLY;
            S_CHAR_FLY: if (character_landed) begin
                if (jumps == JW'(JUMPS_PER_LEVEL - 1)) begin
                    if (level == LVW'(LEVELS - 1)) begin
                        state_nxt = S_END_W;
                    end else begin
                        level_nxt = level + 1'b1;
                        jumps_nxt = '0;
                        state_nxt = S_PREPARE_MAP;
                    end
                end else begin
                    jumps_nxt = jumps + 1'b1;
                    state_nxt = S_GAME_IDLE;
                end
            end
            S_CHAR_FALL: if (character_landed) begin
                if (lives_left <= LW'(1)) begin
                    lives_nxt = '0;
                    state_nxt = S_END_F;
                end else begin
                    lives_nxt = lives_left - 1'b1;
                    jumps_nxt = '0;
                    state_nxt = S_PREPARE_MAP;
                end
            end
            S_END_T, S_END_F, S_END_W: if (space_evt) state_nxt = S_START;
`ifdef GAME_FSM_PAUSE_EN
            S_PAUSED: if (space_evt) state_nxt = S_GAME_IDLE;
`endif
            default: state_nxt = S_START;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_START;
            lives_left <= LW'(LIVES);
            level      <= '0;
            jumps      <= '0;
            cd         <= '0;
            outs       <= decode(S_START);
        end else begin
            state      <= state_nxt;
            lives_left <= lives_nxt;
            level      <= level_nxt;
            jumps      <= jumps_nxt;
            cd         <= cd_nxt;
            outs       <= decode(state_nxt);
        end
    end

    assign start_screen_en = outs.start_screen;
    assign blocks_en       = outs.game;
    assign time_bar_en     = outs.game;
    assign character_en    = outs.game;
    assign points_en       = outs.game;
    assign bg_color_select = outs.game;
    assign end_screen_en   = outs.end_screen;
    assign jump_left       = outs.jump_left;
    assign jump_right      = outs.jump_right;
    assign timer_start     = outs.timer_start;
    assign layer_generate  = outs.layer_gen;
    assign countdown_en    = outs.countdown;
    assign paused          = outs.paused;
    assign end_text_select = outs.end_text;

endmodule

// File: tb/tb_game_fsm_multilevel.sv
// Directed bench for game_fsm_multilevel with a per-cycle behavioural reference model.
module tb_game_fsm_multilevel;

    localparam int LIVES  = 3;
    localparam int LEVELS = 4;
    localparam int JPL    = 8;
    localparam int RT     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] key = 2'b00;
    logic tick = 1'b0, map_ready = 1'b0, jump_fail = 1'b0;
    logic time_elapsed = 1'b0, character_landed = 1'b0;

    logic start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en;
    logic bg_color_select, jump_left, jump_right, timer_start, layer_generate, countdown_en, paused;
    logic [1:0] end_text_select;
    logic [1:0] lives_left;
    logic [1:0] level;

    int checks = 0;
    int errors = 0;

    game_fsm_multilevel #(
        .LIVES(LIVES), .LEVELS(LEVELS), .JUMPS_PER_LEVEL(JPL), .READY_TICKS(RT)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .tick(tick), .map_ready(map_ready),
        .jump_fail(jump_fail), .time_elapsed(time_elapsed), .character_landed(character_landed),
        .start_screen_en(start_screen_en), .blocks_en(blocks_en), .time_bar_en(time_bar_en),
        .character_en(character_en), .points_en(points_en), .end_screen_en(end_screen_en),
        .bg_color_select(bg_color_select), .jump_left(jump_left), .jump_right(jump_right),
        .timer_start(timer_start), .layer_generate(layer_generate), .countdown_en(countdown_en),
        .paused(paused), .end_text_select(end_text_select), .lives_left(lives_left), .level(level)
    );

    always #5 clk = ~clk;

    // Reference model: game mode by name plus plain integer counters.
    string m_mode = "START";
    int m_lives = LIVES, m_level = 0, m_jumps = 0, m_cd = 0;
    logic [1:0] m_kq = 2'b00;
    bit armed = 0;

    function automatic logic [14:0] exp_out(string m);
        logic st, gm, en, jl, jr, ts, lg, cd, pa;
        logic [1:0] tx;
        st = (m == "START") || (m == "PREP");
        gm = (m == "COUNT") || (m == "IDLE") || (m == "JL") || (m == "JR") ||
             (m == "FLY") || (m == "FALL") || (m == "PAUSED");
        en = (m == "END_T") || (m == "END_F") || (m == "END_W");
        jl = (m == "JL");
        jr = (m == "JR");
        ts = (m == "JL") || (m == "JR") || (m == "FLY") || (m == "FALL");
        lg = (m == "PREP");
        cd = (m == "COUNT");
        pa = (m == "PAUSED");
        tx = (m == "END_F") ? 2'b01 : (m == "END_W") ? 2'b10 : 2'b00;
        return {st, gm, gm, gm, gm, en, gm, jl, jr, ts, lg, cd, pa, tx};
    endfunction

    always @(posedge clk) begin : model
        logic evt, sp;
        logic [1:0] k;
        logic [14:0] dut_v, exp_v;
        k   = key;
        evt = (k != m_kq) && (k != 2'b00);
        sp  = evt && (k == 2'b11);
        if (rst) begin
            m_mode = "START"; m_lives = LIVES; m_level = 0; m_jumps = 0; m_cd = 0;
            m_kq = 2'b00; armed = 1;
        end else begin
            m_kq = k;
            if (m_mode == "START") begin
                if (sp) begin m_lives = LIVES; m_level = 0; m_jumps = 0; m_mode = "PREP"; end
            end else if (m_mode == "PREP") begin
                if (map_ready) begin m_cd = RT; m_mode = (RT == 0) ? "IDLE" : "COUNT"; end
            end else if (m_mode == "COUNT") begin
                if (tick) begin
                    if (m_cd <= 1) m_mode = "IDLE";
                    if (m_cd > 0) m_cd = m_cd - 1;
                end
            end else if (m_mode == "IDLE") begin
                if (jump_fail) m_mode = "FALL";
                else if (time_elapsed) m_mode = "END_T";
                else if (evt && k == 2'b01) m_mode = "JL";
                else if (evt && k == 2'b10) m_mode = "JR";
`ifdef GAME_FSM_PAUSE_EN
                else if (sp) m_mode = "PAUSED";
`endif
            end else if (m_mode == "JL" || m_mode == "JR") begin
                m_mode = "FLY";
            end else if (m_mode == "FLY") begin
                if (character_landed) begin
                    if (m_jumps + 1 == JPL) begin
                        if (m_level == LEVELS - 1) m_mode = "END_W";
                        else begin m_level++; m_jumps = 0; m_mode = "PREP"; end
                    end else begin
                        m_jumps++; m_mode = "IDLE";
                    end
                end
            end else if (m_mode == "FALL") begin
                if (character_landed) begin
                    if (m_lives <= 1) begin m_lives = 0; m_mode = "END_F"; end
                    else begin m_lives--; m_jumps = 0; m_mode = "PREP"; end
                end
            end else if (m_mode == "PAUSED") begin
                if (sp) m_mode = "IDLE";
            end else begin
                if (sp) m_mode = "START";
            end
        end
        #1;
        if (armed) begin
            dut_v = {start_screen_en, blocks_en, time_bar_en, character_en, points_en,
                     end_screen_en, bg_color_select, jump_left, jump_right, timer_start,
                     layer_generate, countdown_en, paused, end_text_select};
            exp_v = exp_out(m_mode);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t mode=%s got=%b expected=%b", $time, m_mode, dut_v, exp_v);
            end
            checks++;
            if (int'(lives_left) != m_lives || int'(level) != m_level) begin
                errors++;
                $display("FAIL counters t=%0t got lives=%0d level=%0d expected lives=%0d level=%0d",
                         $time, lives_left, level, m_lives, m_level);
            end
        end
    end

    task automatic lit(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(logic [1:0] k);
        key = k; cyc(1);
        key = 2'b00; cyc(1);
    endtask

    task automatic start_round();
        map_ready = 1'b1; cyc(1); map_ready = 1'b0;
        repeat (RT) begin
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        end
    endtask

    task automatic do_jump(logic [1:0] k);
        key = k; cyc(1);
        key = 2'b00; cyc(1);
        character_landed = 1'b1; cyc(1); character_landed = 1'b0;
    endtask

    initial begin
        int n_lg, n_jl, n_ts;
        cyc(2);
        lit("reset_start_screen", start_screen_en, 1);
        lit("reset_lives", lives_left, 3);
        lit("reset_level", level, 0);
        lit("reset_blocks", blocks_en, 0);
        rst = 1'b0;

        // Space held for 10 cycles acts once.
        key = 2'b11; n_lg = 0;
        for (int i = 0; i < 10; i++) begin cyc(1); n_lg += layer_generate; end
        lit("space_held_prep_cycles", n_lg, 10);
        key = 2'b00; cyc(1);
        map_ready = 1'b1; cyc(1); map_ready = 1'b0;
        lit("countdown_on", countdown_en, 1);
        for (int i = 0; i < RT; i++) begin
            if (i == RT - 1) lit("countdown_before_last_tick", countdown_en, 1);
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        end
        lit("idle_after_countdown_cd", countdown_en, 0);
        lit("idle_after_countdown_blocks", blocks_en, 1);

        // Left held 5 cycles: a single jump strobe, timer runs through the flight.
        key = 2'b01; n_jl = 0; n_ts = 0;
        for (int i = 0; i < 5; i++) begin cyc(1); n_jl += jump_left; n_ts += timer_start; end
        lit("held_left_jump_pulses", n_jl, 1);
        lit("held_left_timer_cycles", n_ts, 5);
        key = 2'b00;
        character_landed = 1'b1; cyc(1); character_landed = 1'b0;
        lit("landed_timer_off", timer_start, 0);
        lit("model_jumps_after_one", m_jumps, 1);

        for (int j = 1; j < JPL; j++) do_jump((j % 2) ? 2'b10 : 2'b01);
        lit("level_cleared_level", level, 1);
        lit("level_cleared_layer_gen", layer_generate, 1);
        start_round();
        for (int j = 0; j < JPL; j++) do_jump(2'b10);
        start_round();
        lit("level_two", level, 2);

        // Stray inputs in GAME_IDLE are ignored; then reset mid-flight.
        tick = 1'b1; character_landed = 1'b1; map_ready = 1'b1; cyc(1);
        tick = 1'b0; character_landed = 1'b0; map_ready = 1'b0;
        lit("stray_inputs_idle", blocks_en, 1);
        key = 2'b01; cyc(1); key = 2'b00; cyc(1);
        lit("in_flight_before_rst", timer_start, 1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        lit("rst_flight_vector", {start_screen_en, blocks_en, end_screen_en, timer_start,
                                  layer_generate, countdown_en, paused, jump_left}, 8'b1000_0000);
        lit("rst_flight_lives", lives_left, 3);
        lit("rst_flight_level", level, 0);

        // Full win through all levels.
        press(2'b11); start_round();
        for (int lv = 0; lv < LEVELS; lv++) begin
            for (int j = 0; j < JPL; j++) do_jump((j % 2) ? 2'b01 : 2'b10);
            if (lv < LEVELS - 1) start_round();
        end
        lit("win_end_screen", end_screen_en, 1);
        lit("win_text", end_text_select, 2);
        lit("win_level", level, 3);
        press(2'b01);
        lit("end_ignores_left", end_screen_en, 1);
        press(2'b11);
        lit("win_back_to_start", start_screen_en, 1);

        // Three falls, with jump_fail and time_elapsed together.
        press(2'b11); start_round();
        do_jump(2'b01);
        for (int f = 0; f < LIVES; f++) begin
            jump_fail = 1'b1; time_elapsed = 1'b1; cyc(1);
            jump_fail = 1'b0; time_elapsed = 1'b0;
            lit("fall_beats_timeout", timer_start, 1);
            character_landed = 1'b1; cyc(1); character_landed = 1'b0;
            lit("lives_after_fall", lives_left, LIVES - 1 - f);
            if (f < LIVES - 1) start_round();
        end
        lit("fell_end_screen", end_screen_en, 1);
        lit("fell_text", end_text_select, 1);
        lit("model_lives_zero", m_lives, 0);
        press(2'b11);

        // Time-out.
        press(2'b11); start_round();
        time_elapsed = 1'b1; cyc(1); time_elapsed = 1'b0;
        lit("timeout_end_screen", end_screen_en, 1);
        lit("timeout_text", end_text_select, 0);
        press(2'b11);

        // Space in GAME_IDLE.
        press(2'b11); start_round();
        press(2'b11);
`ifdef GAME_FSM_PAUSE_EN
        lit("pause_on", paused, 1);
        lit("pause_timer_held", timer_start, 0);
        time_elapsed = 1'b1; jump_fail = 1'b1; cyc(1);
        time_elapsed = 1'b0; jump_fail = 1'b0;
        lit("pause_ignores_faults", paused, 1);
        press(2'b11);
        lit("pause_off", paused, 0);
        lit("resume_blocks", blocks_en, 1);
`else
        lit("no_pause_paused", paused, 0);
        lit("no_pause_blocks", blocks_en, 1);
`endif
        time_elapsed = 1'b1; cyc(1); time_elapsed = 1'b0; cyc(1);
        lit("final_timeout", end_screen_en, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
